// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
// State encoding, requester count, bus widths and slave-select bit.
package apb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int SEL_BIT = 31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: the requester not served last wins a tie.
// Purely combinational; the caller owns the last-grant pointer.
module apb_rr_arbiter
    import apb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (req)
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = req;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between two requesters.
// Define APB_ARB_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT_CYCLES.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NUM_REQ-1:0]  REQ_VALID,
    input  logic [NUM_REQ-1:0]  REQ_WRITE,
    input  logic [ADDR_W-1:0]   REQ_ADDR0,
    input  logic [ADDR_W-1:0]   REQ_ADDR1,
    input  logic [DATA_W-1:0]   REQ_WDATA0,
    input  logic [DATA_W-1:0]   REQ_WDATA1,
    input  logic [STRB_W-1:0]   REQ_STRB0,
    input  logic [STRB_W-1:0]   REQ_STRB1,
    output logic [NUM_REQ-1:0]  REQ_DONE,
    output logic [DATA_W-1:0]   REQ_RDATA,
    output logic                REQ_ERR,
    output logic                PSEL1,
    output logic                PSEL2,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [STRB_W-1:0]   PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t               state;
    state_t               state_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 last_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [STRB_W-1:0]    strb_q;
    logic                 write_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 err_q;
    logic                 timeout;
    logic                 take;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [STRB_W-1:0]    sel_strb;
    logic                 sel_write;

    apb_rr_arbiter u_rr (
        .req   (REQ_VALID),
        .last  (last_q),
        .grant (grant)
    );

    assign take = (state == IDLE) && (|REQ_VALID);

    always_comb begin
        sel_addr  = grant[1] ? REQ_ADDR1  : REQ_ADDR0;
        sel_wdata = grant[1] ? REQ_WDATA1 : REQ_WDATA0;
        sel_strb  = grant[1] ? REQ_STRB1  : REQ_STRB0;
        sel_write = grant[1] ? REQ_WRITE[1] : REQ_WRITE[0];
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state_nxt == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the last permitted stalled ACCESS cycle.
    assign timeout = (state == ACCESS) && !PREADY &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|REQ_VALID) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        PSEL1    = 1'b0;
        PSEL2    = 1'b0;
        PENABLE  = 1'b0;
        REQ_DONE = '0;
        unique case (state)
            IDLE: ;
            SETUP: begin
                PSEL1 = !addr_q[SEL_BIT];
                PSEL2 = addr_q[SEL_BIT];
            end
            ACCESS: begin
                PSEL1   = !addr_q[SEL_BIT];
                PSEL2   = addr_q[SEL_BIT];
                PENABLE = 1'b1;
            end
            DONE: REQ_DONE = grant_q;
        endcase
    end

    // Request fields are frozen at grant; later requester changes are ignored.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            grant_q <= '0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (take) begin
                grant_q <= grant;
                last_q  <= grant[1];
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                strb_q  <= sel_write ? sel_strb : '0;
                write_q <= sel_write;
            end
            if (state == ACCESS && PREADY) begin
                rdata_q <= write_q ? '0 : PRDATA;
                err_q   <= PSLVERR;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;
    assign PSTRB     = strb_q;
    assign PWRITE    = write_q;
    assign REQ_RDATA = rdata_q;
    assign REQ_ERR   = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench: cycle-level arbitration model predicts grants and
// completions; an APB slave model checks the bus side.
module tb_apb_req_arbiter;

    localparam int TO = 16;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } rq_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          done_cyc;
    } xf_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_strb [2];
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        psel1, psel2, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    apb_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK       (clk),
        .PRESET     (rst),
        .REQ_VALID  (req_valid),
        .REQ_WRITE  (req_write),
        .REQ_ADDR0  (req_addr[0]),
        .REQ_ADDR1  (req_addr[1]),
        .REQ_WDATA0 (req_wdata[0]),
        .REQ_WDATA1 (req_wdata[1]),
        .REQ_STRB0  (req_strb[0]),
        .REQ_STRB1  (req_strb[1]),
        .REQ_DONE   (req_done),
        .REQ_RDATA  (req_rdata),
        .REQ_ERR    (req_err),
        .PSEL1      (psel1),
        .PSEL2      (psel2),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PSTRB      (pstrb),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    xf_t sb_q [$];
    xf_t plan_q [$];
    rq_t lst [2][$];
    rq_t cur [2];
    bit  pend [2];
    bit  busy [2];
    int  gap [2];
    int  rdone [2];
    bit  rand_gap;
    bit  last_g;
    int  free_cyc;

    function automatic rq_t mk(logic [31:0] a, logic w, logic [31:0] d,
                               logic [3:0] s, int wt, logic [31:0] rd,
                               logic e);
        rq_t r;
        r.addr = a; r.wr = w; r.wdata = d; r.strb = s;
        r.waits = wt; r.rdata = rd; r.err = e;
        return r;
    endfunction

    function automatic rq_t rnd_rq();
        return mk($urandom, 1'($urandom), $urandom, 4'($urandom),
                  $urandom_range(0, 3), $urandom,
                  $urandom_range(0, 7) == 0);
    endfunction

    function automatic int outstanding();
        int t;
        t = sb_q.size() + lst[0].size() + lst[1].size();
        for (int n = 0; n < 2; n++) t += int'(pend[n]) + int'(busy[n]);
        return t;
    endfunction

    // Bus is free again one cycle after the DONE cycle; ties go to
    // whichever requester was not served last.
    task automatic grant_model();
        int  g;
        xf_t x;
        if (pend[0] && pend[1]) g = last_g ? 0 : 1;
        else g = pend[0] ? 0 : 1;
        x.id = g;
        x.addr = cur[g].addr;
        x.wr = cur[g].wr;
        x.wdata = cur[g].wdata;
        x.strb = cur[g].wr ? cur[g].strb : 4'h0;
        x.waits = cur[g].waits;
        x.rdata = cur[g].rdata;
        x.err = cur[g].err;
        x.exp_rdata = cur[g].wr ? 32'h0 : cur[g].rdata;
        x.exp_err = cur[g].err;
        x.done_cyc = cyc + 3 + cur[g].waits;
`ifdef APB_ARB_TIMEOUT_EN
        if (cur[g].waits >= TO) begin
            x.exp_rdata = 32'h0;
            x.exp_err = 1'b1;
            x.done_cyc = cyc + 2 + TO;
        end
`endif
        free_cyc = x.done_cyc + 1;
        last_g = (g == 1);
        pend[g] = 1'b0;
        busy[g] = 1'b1;
        rdone[g] = x.done_cyc;
        sb_q.push_back(x);
        plan_q.push_back(x);
    endtask

    task automatic step();
        for (int n = 0; n < 2; n++) begin
            if (busy[n] && cyc == rdone[n]) begin
                busy[n] = 1'b0;
                gap[n] = rand_gap ? $urandom_range(0, 2) : 0;
            end
            if (busy[n]) begin
                req_addr[n] = $urandom;
                req_wdata[n] = $urandom;
                req_strb[n] = 4'($urandom);
                req_write[n] = 1'($urandom);
            end else if (!pend[n] && lst[n].size() > 0) begin
                if (gap[n] > 0) begin
                    gap[n]--;
                end else begin
                    cur[n] = lst[n].pop_front();
                    pend[n] = 1'b1;
                    req_addr[n] = cur[n].addr;
                    req_wdata[n] = cur[n].wdata;
                    req_strb[n] = cur[n].strb;
                    req_write[n] = cur[n].wr;
                end
            end
            req_valid[n] = pend[n] || busy[n];
        end
        if (cyc >= free_cyc && (pend[0] || pend[1])) grant_model();
        @(negedge clk);
    endtask

    task automatic drain(int budget);
        for (int i = 0; i < budget && outstanding() > 0; i++) step();
        chk("drain_outstanding", outstanding(), 0);
    endtask

    task automatic chk_zero(string name);
        chk(name, {psel1, psel2, penable, pwrite, req_done, req_err}, 0);
        chk(name, {paddr, pwdata}, 0);
        chk(name, {pstrb, req_rdata}, 0);
    endtask

    task automatic do_reset(int hold);
        rst = 1'b1;
        #1;
        chk_zero("rst_now");
        sb_q.delete();
        plan_q.delete();
        for (int n = 0; n < 2; n++) begin
            lst[n].delete();
            pend[n] = 1'b0;
            busy[n] = 1'b0;
            gap[n] = 0;
        end
        req_valid = 2'b00;
        last_g = 1'b1;
        repeat (hold) @(negedge clk);
        chk_zero("rst_hold");
        rst = 1'b0;
        free_cyc = cyc;
    endtask

    xf_t sp;
    bit  s_act = 1'b0;
    int  s_cnt = 0;

    // APB slave: consumes the planned response and checks bus stability.
    always @(negedge clk) begin
        if (rst) begin
            s_act = 1'b0;
            pready = 1'b0;
            pslverr = 1'b0;
            prdata = 32'h0;
        end else if (psel1 || psel2) begin
            if (!penable) begin
                if (plan_q.size() == 0) begin
                    chk("setup_unplanned", {psel1, psel2}, 0);
                end else begin
                    sp = plan_q.pop_front();
                    s_act = 1'b1;
                    s_cnt = 0;
                    chk("setup_sel", {psel1, psel2},
                        {~sp.addr[31], sp.addr[31]});
                    chk("setup_addr", paddr, sp.addr);
                    chk("setup_ctl", {pwrite, pstrb}, {sp.wr, sp.strb});
                    if (sp.wr) chk("setup_wdata", pwdata, sp.wdata);
                end
                pready = 1'b0;
                prdata = $urandom;
                pslverr = 1'($urandom);
            end else if (s_act) begin
                chk("access_hold", {psel1, psel2, paddr, pwrite, pstrb},
                    {~sp.addr[31], sp.addr[31], sp.addr, sp.wr, sp.strb});
                if (sp.wr) chk("access_wdata", pwdata, sp.wdata);
                if (s_cnt == sp.waits) begin
                    pready = 1'b1;
                    prdata = sp.rdata;
                    pslverr = sp.err;
                end else begin
                    pready = 1'b0;
                    prdata = $urandom;
                    pslverr = 1'($urandom);
                end
                s_cnt++;
            end
        end else begin
            s_act = 1'b0;
            pready = 1'b0;
            pslverr = 1'b0;
        end
    end

    xf_t mx;

    // Completion monitor: pops the scoreboard on the predicted DONE cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].done_cyc == cyc) begin
                mx = sb_q.pop_front();
                chk("done_req", req_done, mx.id == 1 ? 2'b10 : 2'b01);
                chk("done_rdata", req_rdata, mx.exp_rdata);
                chk("done_err", req_err, mx.exp_err);
            end else if (req_done != 2'b00) begin
                chk("done_spurious", req_done, 0);
            end
        end
    end

    initial begin
        req_valid = 2'b00;
        req_write = 2'b00;
        for (int n = 0; n < 2; n++) begin
            req_addr[n] = 32'h0;
            req_wdata[n] = 32'h0;
            req_strb[n] = 4'h0;
            pend[n] = 1'b0;
            busy[n] = 1'b0;
            gap[n] = 0;
            rdone[n] = 0;
        end
        rand_gap = 1'b0;
        last_g = 1'b1;
        free_cyc = 0;
        #1 rst = 1'b1;
        @(negedge clk);
        do_reset(2);

        // Both requesters held valid: 0,1,0,1 at zero wait states.
        for (int i = 0; i < 2; i++) begin
            lst[0].push_back(mk(32'h0000_0100 + 32'(i * 4), 1'b1,
                                32'hA000_0000 + 32'(i), 4'h3, 0,
                                32'h0, 1'b0));
            lst[1].push_back(mk(32'h8000_0100 + 32'(i * 4), 1'b0,
                                32'h0, 4'hF, 0,
                                32'hB000_0000 + 32'(i), 1'b0));
        end
        drain(200);

        lst[0].push_back(mk(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0,
                            32'hFFFF_FFFF, 1'b0));
        drain(200);

        lst[1].push_back(mk(32'h8000_0004, 1'b0, 32'h5555_5555, 4'hA, 3,
                            32'h1234_5678, 1'b0));
        drain(200);

        lst[0].push_back(mk(32'h0000_0020, 1'b0, 32'h0, 4'h0, 0,
                            32'hCAFE_0001, 1'b1));
        drain(200);

        // Reset in the middle of a stalled ACCESS.
        lst[1].push_back(mk(32'h8000_0040, 1'b0, 32'h0, 4'h0, 5,
                            32'h0000_0001, 1'b0));
        for (int i = 0; i < 20 && !busy[1]; i++) step();
        step();
        step();
        chk("pre_rst_access", {penable, psel2}, {1'b1, busy[1]});
        do_reset(2);
        lst[0].push_back(rnd_rq());
        lst[1].push_back(rnd_rq());
        drain(200);

`ifdef APB_ARB_TIMEOUT_EN
        lst[0].push_back(mk(32'h0000_0080, 1'b0, 32'h0, 4'h0, 1000,
                            32'hFFFF_0000, 1'b0));
        drain(200);
`endif

        rand_gap = 1'b1;
        for (int i = 0; i < 40; i++) begin
            lst[0].push_back(rnd_rq());
            lst[1].push_back(rnd_rq());
        end
        drain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
